// File: rtl/lut_function_unit.sv
// Run-time loadable truth-table evaluator: N_FUNC functions of N_IN shared inputs,
// serial table load, valid/ready evaluation. Define LUTFN_EVAL_COUNT_EN to add eval_count.
module lut_function_unit #(
    parameter int N_IN   = 3,
    parameter int N_FUNC = 4,
    localparam int CFG_W = (N_FUNC > 1) ? $clog2(N_FUNC) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    input  logic [CFG_W-1:0]  cfg_func,
    input  logic              cfg_bit_valid,
    input  logic              cfg_bit,
    output logic              cfg_busy,
    output logic              cfg_err,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_IN-1:0]   in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_FUNC-1:0] out_data
`ifdef LUTFN_EVAL_COUNT_EN
    ,
    output logic [15:0]       eval_count
`endif
);

    localparam int TBL_W = 1 << N_IN;
    localparam int CNT_W = N_IN + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(TBL_W - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CFG_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [TBL_W-1:0]    shift_q, shift_d;
    logic [TBL_W-1:0]    table_q [N_FUNC];
    logic [TBL_W-1:0]    table_d [N_FUNC];
    logic                out_valid_q, out_valid_d;
    logic [N_FUNC-1:0]   out_data_q, out_data_d;
    logic                cfg_err_q, cfg_err_d;
    logic                commit_s;
    logic                start_ok_s;
    logic                in_ready_s;
    logic                accept_s;

    assign start_ok_s = cfg_start && (32'(cfg_func) < N_FUNC);
    assign in_ready_s = (state_q == ST_IDLE) && !cfg_start && (!out_valid_q || out_ready);
    assign accept_s   = in_valid && in_ready_s;

    assign cfg_busy  = (state_q == ST_LOAD);
    assign cfg_err   = cfg_err_q;
    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Load FSM: bits enter at the MSB so the first bit ends up as entry 0.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        cfg_err_d = 1'b0;
        commit_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d = ST_LOAD;
                    idx_d   = cfg_func;
                    cnt_d   = '0;
                    shift_d = '0;
                end else if (cfg_start) begin
                    cfg_err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (cfg_bit_valid) begin
                    shift_d = {cfg_bit, shift_q[TBL_W-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
                        commit_s = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Whole-table commit on the final bit; old table stays live until then.
    always_comb begin
        for (int f = 0; f < N_FUNC; f++) begin
            if (commit_s && (32'(idx_q) == 32'(f))) begin
                table_d[f] = shift_d;
            end else begin
                table_d[f] = table_q[f];
            end
        end
    end

    // Result register: capture on accept, hold while stalled.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (accept_s) begin
            out_valid_d = 1'b1;
            for (int f = 0; f < N_FUNC; f++) begin
                out_data_d[f] = table_q[f][in_data];
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State, table and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            shift_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_err_q   <= 1'b0;
            for (int f = 0; f < N_FUNC; f++) begin
                table_q[f] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            cfg_err_q   <= cfg_err_d;
            table_q     <= table_d;
        end
    end

`ifdef LUTFN_EVAL_COUNT_EN
    logic [15:0] eval_count_q, eval_count_d;

    // Saturating count of accepted input vectors.
    always_comb begin
        if (accept_s && (eval_count_q != 16'hFFFF)) begin
            eval_count_d = eval_count_q + 16'd1;
        end else begin
            eval_count_d = eval_count_q;
        end
    end

    // Counter register, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eval_count_q <= 16'd0;
        end else begin
            eval_count_q <= eval_count_d;
        end
    end

    assign eval_count = eval_count_q;
`endif

endmodule

// File: tb/tb_lut_function_unit.sv
// Directed, table-driven bench for lut_function_unit (N_IN=3, N_FUNC=4) plus an
// N_FUNC=5 instance for the out-of-range start case.
module tb_lut_function_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_start, cfg_bit_valid, cfg_bit;
    logic [1:0] cfg_func;
    logic       cfg_busy, cfg_err;
    logic       in_valid, in_ready, out_valid, out_ready;
    logic [2:0] in_data;
    logic [3:0] out_data;

    logic       c5_start, c5_bit_valid, c5_bit, c5_busy, c5_err;
    logic [2:0] c5_func;
    logic       c5_in_valid, c5_in_ready, c5_out_valid, c5_out_ready;
    logic [2:0] c5_in_data;
    logic [4:0] c5_out_data;

`ifdef LUTFN_EVAL_COUNT_EN
    logic [15:0] eval_count, c5_eval_count;
`endif

    int total = 0;
    int bad   = 0;
    int n_acc = 0;

    typedef struct {
        logic [2:0] din;
        logic [3:0] exp;
    } vec_t;
    vec_t vecs [8];

    always #5 clk = ~clk;

    lut_function_unit #(.N_IN(3), .N_FUNC(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_func(cfg_func),
        .cfg_bit_valid(cfg_bit_valid), .cfg_bit(cfg_bit),
        .cfg_busy(cfg_busy), .cfg_err(cfg_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef LUTFN_EVAL_COUNT_EN
        , .eval_count(eval_count)
`endif
    );

    lut_function_unit #(.N_IN(3), .N_FUNC(5)) dut5 (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(c5_start), .cfg_func(c5_func),
        .cfg_bit_valid(c5_bit_valid), .cfg_bit(c5_bit),
        .cfg_busy(c5_busy), .cfg_err(c5_err),
        .in_valid(c5_in_valid), .in_ready(c5_in_ready), .in_data(c5_in_data),
        .out_valid(c5_out_valid), .out_ready(c5_out_ready), .out_data(c5_out_data)
`ifdef LUTFN_EVAL_COUNT_EN
        , .eval_count(c5_eval_count)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One accept with out_ready high, result checked the following cycle.
    task automatic eval1(input logic [2:0] din, input logic [3:0] exp);
        in_valid = 1'b1;
        in_data  = din;
        #1;
        chk("eval_in_ready", 32'(in_ready), 32'd1);
        step();
        n_acc++;
        chk("eval_out_valid", 32'(out_valid), 32'd1);
        chk("eval_out_data", 32'(out_data), 32'(exp));
    endtask

    task automatic idle();
        in_valid = 1'b0;
        step();
        chk("idle_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic load(input logic [1:0] f, input logic [7:0] v, input bit gaps);
        cfg_start = 1'b1;
        cfg_func  = f;
        #1;
        chk("start_in_ready", 32'(in_ready), 32'd0);
        step();
        cfg_start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (gaps && (k % 3 == 1)) begin
                cfg_bit_valid = 1'b0;
                cfg_start     = 1'b1;
                cfg_func      = f + 2'd1;
                #1;
                chk("gap_busy", 32'(cfg_busy), 32'd1);
                chk("gap_in_ready", 32'(in_ready), 32'd0);
                step();
                cfg_start = 1'b0;
                chk("gap_no_err", 32'(cfg_err), 32'd0);
            end
            cfg_bit_valid = 1'b1;
            cfg_bit       = v[k];
            #1;
            chk("load_busy", 32'(cfg_busy), 32'd1);
            chk("load_in_ready", 32'(in_ready), 32'd0);
            step();
            chk("load_out_valid", 32'(out_valid), 32'd0);
        end
        cfg_bit_valid = 1'b0;
        #1;
        chk("post_load_busy", 32'(cfg_busy), 32'd0);
        chk("post_load_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        // func0 = E8 (majority), func2 = FE, func1/func3 = 0
        vecs[0] = '{3'd0, 4'b0000};
        vecs[1] = '{3'd1, 4'b0100};
        vecs[2] = '{3'd2, 4'b0100};
        vecs[3] = '{3'd3, 4'b0101};
        vecs[4] = '{3'd4, 4'b0100};
        vecs[5] = '{3'd5, 4'b0101};
        vecs[6] = '{3'd6, 4'b0101};
        vecs[7] = '{3'd7, 4'b0101};

        rst_n = 1'b0;
        cfg_start = 1'b0; cfg_func = 2'd0; cfg_bit_valid = 1'b0; cfg_bit = 1'b0;
        in_valid = 1'b0; in_data = 3'd0; out_ready = 1'b1;
        c5_start = 1'b0; c5_func = 3'd0; c5_bit_valid = 1'b0; c5_bit = 1'b0;
        c5_in_valid = 1'b0; c5_in_data = 3'd0; c5_out_ready = 1'b1;

        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(cfg_busy), 32'd0);
        chk("rst_err", 32'(cfg_err), 32'd0);
`ifdef LUTFN_EVAL_COUNT_EN
        chk("rst_eval_count", 32'(eval_count), 32'd0);
`endif
        rst_n = 1'b1;
        step();

        eval1(3'b101, 4'b0000);
        idle();

        // Input held valid across the load; it is accepted with the new table.
        in_valid = 1'b1;
        in_data  = 3'b011;
        load(2'd0, 8'hE8, 1'b0);
        step();
        n_acc++;
        chk("new_table_out_valid", 32'(out_valid), 32'd1);
        chk("new_table_out_data", 32'(out_data), 32'b0001);
        eval1(3'b001, 4'b0000);
        idle();

        load(2'd2, 8'hFE, 1'b1);
        for (int i = 0; i < 8; i++) begin
            eval1(vecs[i].din, vecs[i].exp);
        end
        idle();

        eval1(3'b111, 4'b0101);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 3'b000;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_in_ready", 32'(in_ready), 32'd0);
            step();
            chk("hold_out_valid", 32'(out_valid), 32'd1);
            chk("hold_out_data", 32'(out_data), 32'b0101);
        end
        out_ready = 1'b1;
        eval1(3'b000, 4'b0000);
        eval1(3'b011, 4'b0101);
        idle();
`ifdef LUTFN_EVAL_COUNT_EN
        chk("eval_count", 32'(eval_count), 32'(n_acc));
`endif

        c5_start = 1'b1;
        c5_func  = 3'd5;
        #1;
        chk("err_in_ready", 32'(c5_in_ready), 32'd0);
        step();
        c5_start = 1'b0;
        chk("err_pulse", 32'(c5_err), 32'd1);
        chk("err_busy", 32'(c5_busy), 32'd0);
        step();
        chk("err_pulse_end", 32'(c5_err), 32'd0);
        chk("err_busy_after", 32'(c5_busy), 32'd0);
        c5_in_valid = 1'b1;
        c5_in_data  = 3'b111;
        step();
        c5_in_valid = 1'b0;
        chk("err_tbl_valid", 32'(c5_out_valid), 32'd1);
        chk("err_tbl_data", 32'(c5_out_data), 32'd0);
        chk("main_no_err", 32'(cfg_err), 32'd0);

        // Reset in the middle of loading func1 with all ones.
        eval1(3'b111, 4'b0101);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        cfg_start = 1'b1;
        cfg_func  = 2'd1;
        step();
        cfg_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cfg_bit_valid = 1'b1;
            cfg_bit       = 1'b1;
            step();
        end
        cfg_bit_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(cfg_busy), 32'd0);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_data", 32'(out_data), 32'd0);
`ifdef LUTFN_EVAL_COUNT_EN
        chk("midrst_eval_count", 32'(eval_count), 32'd0);
`endif
        n_acc = 0;
        out_ready = 1'b1;
        step();
        rst_n = 1'b1;
        step();
        eval1(3'b111, 4'b0000);
        eval1(3'b011, 4'b0000);
        idle();
`ifdef LUTFN_EVAL_COUNT_EN
        chk("final_eval_count", 32'(eval_count), 32'(n_acc));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lut_function_unit.md
# lut_function_unit

- Parametrised, clocked evaluator of `N_FUNC` independent Boolean functions of `N_IN` shared inputs.
- Each function is held as a `2**N_IN`-bit truth table. Tables are loaded at run time over a serial configuration port.
- Input vectors are accepted and results returned over valid/ready handshakes with one-cycle latency.
- Replaces fixed gate-level function blocks in lab datapaths; sits between switch/input sampling logic and LED/display drivers.

## Interface
Parameters:
- `N_IN`, 3: number of function inputs; legal range 1..6.
- `N_FUNC`, 4: number of functions/outputs; legal range 1..16.

Ports:
- `clk` in 1: single clock. All logic is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `cfg_start` in 1: pulse to begin loading table `cfg_func`.
- `cfg_func` in `max(1,$clog2(N_FUNC))`: index of the table to load; sampled with `cfg_start`.
- `cfg_bit_valid` in 1: `cfg_bit` is valid this cycle.
- `cfg_bit` in 1: serial truth-table bit.
- `cfg_busy` out 1: high while loading.
- `cfg_err` out 1: one-cycle pulse when a start is rejected.
- `in_valid` in 1: input vector valid.
- `in_ready` out 1: block accepts `in_data`.
- `in_data` in `N_IN`: input vector.
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts result.
- `out_data` out `N_FUNC`: bit f = function f evaluated at the accepted `in_data`.
- `eval_count` out 16: present only with `LUTFN_EVAL_COUNT_EN`.

## Operation
- Reset values: all tables 0; FSM in IDLE; `out_valid`=0, `out_data`=0, `cfg_busy`=0, `cfg_err`=0, `eval_count`=0.
- FSM states: IDLE and LOAD.
  - IDLE→LOAD on `cfg_start` when `cfg_func < N_FUNC`. Latch the index and clear the bit counter and shift register.
  - If `cfg_start` has `cfg_func >= N_FUNC`, stay in IDLE and pulse `cfg_err` next cycle.
  - In LOAD, each `cfg_bit_valid` cycle shifts in one bit. The first bit is table entry 0 (LSB); bit k is the output for `in_data==k`.
  - Gaps (`cfg_bit_valid`=0) are allowed. `cfg_start` during LOAD is ignored: no restart, no error.
  - After bit `2**N_IN - 1`, the whole table is written in one step (the old table is used until then) and the FSM returns to IDLE.
- `cfg_busy` = (state==LOAD).
- `in_ready` = IDLE && !cfg_start && (!out_valid || out_ready).
  - Evaluation is blocked during loading and in the cycle a load starts. A simultaneous `cfg_start` and `in_valid` gives configuration priority.
- On accept (`in_valid && in_ready`), each `out_data[f]` is registered from `table[f][in_data]` and `out_valid` is set.
- Output hold: while `out_valid && !out_ready`, `out_data` stays stable.
- Output clear: `out_valid` clears on `out_ready` unless a new accept happens in the same cycle.
- A held result is never altered by a later table load.
- Reset asserted mid-load: the partial table is discarded and all tables return to 0.

## Timing
- Evaluation latency: 1 cycle, accept edge to `out_valid`.
- Throughput: 1 result/cycle when `out_ready` is held high.
- Load duration: minimum `2**N_IN` cycles after the start edge.
  - A new table affects inputs accepted from the cycle after its final bit.
  - `in_ready` rises that same cycle.
- `cfg_err` pulse: the cycle after the rejected start, width 1.
- Reset is asserted asynchronously and deasserts synchronously to `clk`. The deassertion synchronizer lives outside this block.

## Configuration
- `LUTFN_EVAL_COUNT_EN` defined: adds port `eval_count`, a 16-bit counter of accepted input vectors.
  - Increments on each accept and saturates at 16'hFFFF.
  - Resets to 0 on reset only.
- `LUTFN_EVAL_COUNT_EN` undefined: no counter and no `eval_count` port. All other behaviour is identical.

## Test plan
Default parameters (N_IN=3, N_FUNC=4).
- Reset, no load; `in_data`=3'b101 with `out_ready`=1 → next cycle `out_valid`=1, `out_data`=4'b0000.
- Load func0 = 8'hE8 (majority), LSB first, 8 bits; then `in_data`=3'b011 → `out_data[0]`=1. `in_data`=3'b001 → `out_data[0]`=0.
- Load func2 = 8'hFE with gaps; `cfg_busy`=1 and `in_ready`=0 for the whole load; apply `in_data`=3'b000 after commit → `out_data[2]`=0. Apply 3'b100 → `out_data[2]`=1.
- `cfg_start` with `cfg_func`=3'd5, N_FUNC=4 (width 2, so drive N_FUNC=5 variant with index 5) → `cfg_err` one-cycle pulse; `cfg_busy` stays 0; tables unchanged.
- `out_ready`=0 for 3 cycles after accepting 3'b111 → `out_data` stable and `in_ready`=0. Raise `out_ready` with `in_valid` high → back-to-back results, no loss.
- Assert `rst_n` low after 4 of 8 bits → all tables 0 and `out_valid`=0. With `LUTFN_EVAL_COUNT_EN`, `eval_count` returns to 0 and otherwise equals the number of accepted vectors.
